// File: rtl/seg7_scan_mux_pkg.sv
// Shared types, constants and the hex-to-segment decoder for the 7-segment scan multiplexer.
package seg7_scan_pkg;

    localparam int         MAX_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK  = 7'h00;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_phase_t;

    // Segment order is {g,f,e,d,c,b,a}; A..F shown as A b C d E F.
    function automatic logic [6:0] seg7_decode(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_tick.sv
// Slot prescaler and digit index for the scan multiplexer; flags slot and frame wraps
// combinationally in the last cycle of a slot / of the last digit's slot.
module scan_tick_gen
    import seg7_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 10000,
    parameter int GHOST_CYCLES = 16
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] idx_o,
    output scan_phase_t                                    phase_o,
    output logic                                           slot_wrap_o,
    output logic                                           frame_wrap_o
);

    localparam int PSC_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PSC_W-1:0] psc_q, psc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_digit;

    always_comb begin
        slot_wrap_o  = (psc_q == PSC_W'(SCAN_DIV - 1));
        last_digit   = (idx_q == IDX_W'(NUM_DIGITS - 1));
        frame_wrap_o = slot_wrap_o && last_digit;
        phase_o      = (psc_q < PSC_W'(GHOST_CYCLES)) ? BLANK : DRIVE;
        idx_o        = idx_q;

        psc_d = psc_q + PSC_W'(1);
        idx_d = idx_q;
        if (slot_wrap_o) begin
            psc_d = '0;
            idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psc_q <= '0;
            idx_q <= '0;
        end else begin
            psc_q <= psc_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver with a double-buffered, frame-synchronous update port.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_mux
    import seg7_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 10000,
    parameter int GHOST_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
        $error("seg7_scan_mux: NUM_DIGITS out of range");
    end
    if (GHOST_CYCLES < 1 || SCAN_DIV <= GHOST_CYCLES) begin : g_bad_timing
        $error("seg7_scan_mux: need 1 <= GHOST_CYCLES < SCAN_DIV");
    end

    logic [IDX_W-1:0] idx;
    scan_phase_t      phase;
    logic             slot_wrap;
    logic             frame_wrap;

    scan_tick_gen #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .GHOST_CYCLES(GHOST_CYCLES)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_o       (idx),
        .phase_o     (phase),
        .slot_wrap_o (slot_wrap),
        .frame_wrap_o(frame_wrap)
    );

    logic [4*NUM_DIGITS-1:0] disp_q, disp_d, shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   dpm_q, dpm_d, shdp_q, shdp_d;
    logic                    pending_q, pending_d;
    logic                    wrap_seen_q, wrap_seen_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    fs_q, fs_d;

    logic                    accept;
    logic                    boundary;
    logic [3:0]              cur_digit;
    logic                    lz_blank;

    always_comb begin
        accept   = upd_valid && !pending_q;
        boundary = slot_wrap && frame_wrap;

        disp_d    = disp_q;
        dpm_d     = dpm_q;
        shadow_d  = shadow_q;
        shdp_d    = shdp_q;
        pending_d = pending_q;

        // Swap reads the shadow as it was before this edge; a same-edge accept only
        // refills the shadow (it can only happen when nothing was pending).
        if (boundary && pending_q) begin
            disp_d    = shadow_q;
            dpm_d     = shdp_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            shadow_d  = upd_data;
            shdp_d    = upd_dp;
            pending_d = 1'b1;
        end

        cur_digit = 4'(disp_q >> {idx, 2'b00});

`ifdef SEG7_SCAN_LZB_EN
        // Blank digit i>0 when it and every more-significant digit are zero.
        lz_blank = (idx != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx) && disp_q[4*j +: 4] != 4'h0) begin
                lz_blank = 1'b0;
            end
        end
`else
        lz_blank = 1'b0;
`endif

        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        en_d  = '0;
        if (phase == DRIVE) begin
            en_d  = NUM_DIGITS'(1) << idx;
            dp_d  = dpm_q[idx];
            seg_d = lz_blank ? SEG_BLANK : seg7_decode(cur_digit);
        end

        wrap_seen_d = boundary;
        fs_d        = wrap_seen_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_q      <= '0;
            dpm_q       <= '0;
            shadow_q    <= '0;
            shdp_q      <= '0;
            pending_q   <= 1'b0;
            wrap_seen_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b0;
            en_q        <= '0;
            fs_q        <= 1'b0;
        end else begin
            disp_q      <= disp_d;
            dpm_q       <= dpm_d;
            shadow_q    <= shadow_d;
            shdp_q      <= shdp_d;
            pending_q   <= pending_d;
            wrap_seen_q <= wrap_seen_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            en_q        <= en_d;
            fs_q        <= fs_d;
        end
    end

    assign upd_ready   = !pending_q;
    assign seg_out     = seg_q;
    assign dp_out      = dp_q;
    assign digit_en    = en_q;
    assign frame_start = fs_q;

endmodule
